// File: rtl/pipe_ctrl.sv
// pipe_ctrl
// Central pipeline sequencer for the 5-stage core. It merges the ID/EX/MEM
// stall requests into a per-stage hold vector and issues a one-cycle flush
// with a redirect PC when MEM commits an exception. It also runs the
// multi-cycle divide handshake: it starts the divider, holds the front of
// the pipe until the result is ready, and aborts on exception or timeout.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   stallreq_id_i    load-use hazard in ID
//   stallreq_ex_i    generic multi-cycle EX stall (not the divider)
//   stallreq_mem_i   MEM bus wait
//   div_req_i        EX holds a DIV/DIVU
//   div_ready_i      divider result valid (1-cycle pulse)
//   excp_valid_i     exception committed in MEM this cycle
//   excp_target_i    exception handler address
//   stall_o          [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB [5]WB, 1 = hold
//   flush_o          clear all pipeline registers (registered pulse)
//   new_pc_o         redirect address, valid while flush_o=1, held afterwards
//   div_start_o      divider start pulse (registered)
//   div_annul_o      divider abort pulse (registered)
//   div_timeout_o    sticky divide-timeout flag, cleared only by rst
//
// DIV_TIMEOUT must be at least 2.

module pipe_ctrl #(
  parameter int PC_W        = 32,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallreq_id_i,
  input  logic            stallreq_ex_i,
  input  logic            stallreq_mem_i,
  input  logic            div_req_i,
  input  logic            div_ready_i,
  input  logic            excp_valid_i,
  input  logic [PC_W-1:0] excp_target_i,
  output logic [5:0]      stall_o,
  output logic            flush_o,
  output logic [PC_W-1:0] new_pc_o,
  output logic            div_start_o,
  output logic            div_annul_o,
  output logic            div_timeout_o
);

  localparam int CNT_W = $clog2(DIV_TIMEOUT + 1);

  // Last DIV_WAIT cycle before the abort, and the saturation ceiling.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV_TIMEOUT);

  // Stall patterns: a stage holds together with every stage upstream of it.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_WAIT = 2'd1,
    DIV_DONE = 2'd2,
    FLUSH    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              flush_q, flush_d;
  logic [PC_W-1:0]   new_pc_q, new_pc_d;
  logic              div_start_q, div_start_d;
  logic              div_annul_q, div_annul_d;
  logic              div_timeout_q, div_timeout_d;
  logic              excp_take;

  // An exception is accepted anywhere except during the flush it caused.
  assign excp_take = excp_valid_i && (state_q != FLUSH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      flush_q       <= 1'b0;
      new_pc_q      <= '0;
      div_start_q   <= 1'b0;
      div_annul_q   <= 1'b0;
      div_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      flush_q       <= flush_d;
      new_pc_q      <= new_pc_d;
      div_start_q   <= div_start_d;
      div_annul_q   <= div_annul_d;
      div_timeout_q <= div_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    flush_d       = 1'b0;
    new_pc_d      = new_pc_q;
    div_start_d   = 1'b0;
    div_annul_d   = 1'b0;
    div_timeout_d = div_timeout_q;
    stall_o       = STALL_NONE;

    // Stall vector, highest match wins. During a flush (or the cycle an
    // exception is seen) nothing may hold, otherwise the flush would be lost.
    // In DIV_DONE the divide no longer holds EX so EX/MEM takes the result.
    if (state_q == FLUSH || excp_valid_i) begin
      stall_o = STALL_NONE;
    end else if (stallreq_mem_i) begin
      stall_o = STALL_MEM;
    end else if (stallreq_ex_i || state_q == DIV_WAIT ||
                 (state_q == IDLE && div_req_i)) begin
      stall_o = STALL_EX;
    end else if (stallreq_id_i) begin
      stall_o = STALL_ID;
    end

    // Exception outranks ready, timeout and every other transition; an
    // in-flight divide must be annulled so the divider drops its operands.
    if (excp_take) begin
      state_d     = FLUSH;
      flush_d     = 1'b1;
      new_pc_d    = excp_target_i;
      div_annul_d = (state_q == DIV_WAIT);
    end else begin
      case (state_q)
        IDLE: begin
          // A MEM bus wait defers the start; the pipe keeps holding meanwhile.
          if (div_req_i && !stallreq_mem_i) begin
            state_d     = DIV_WAIT;
            div_start_d = 1'b1;
          end
        end
        DIV_WAIT: begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
          if (div_ready_i) begin
            state_d = DIV_DONE;
          end else if (cnt_q == CNT_LAST) begin
            state_d       = IDLE;
            div_annul_d   = 1'b1;
            div_timeout_d = 1'b1;
          end
        end
        // div_req is still high here for the departing instruction; going
        // straight to IDLE without looking at it prevents a restart.
        DIV_DONE: state_d = IDLE;
        FLUSH:    state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  assign flush_o       = flush_q;
  assign new_pc_o      = new_pc_q;
  assign div_start_o   = div_start_q;
  assign div_annul_o   = div_annul_q;
  assign div_timeout_o = div_timeout_q;

  // Start and abort are exclusive, and the counter never passes its ceiling.
  a_start_annul_excl: assert property (@(posedge clk) disable iff (rst)
    !(div_start_q && div_annul_q));
  a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
    cnt_q <= CNT_MAX);

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  localparam int PC_W = 32;
  localparam int DT   = 8;

  logic            clk = 1'b1;
  logic            rst;
  logic            stallreq_id, stallreq_ex, stallreq_mem;
  logic            div_req, div_ready, excp_valid;
  logic [PC_W-1:0] excp_target;
  logic [5:0]      stall;
  logic            flush;
  logic [PC_W-1:0] new_pc;
  logic            div_start, div_annul, div_timeout;

  always #5 clk = ~clk;

  pipe_ctrl #(.PC_W(PC_W), .DIV_TIMEOUT(DT)) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_id_i (stallreq_id),
    .stallreq_ex_i (stallreq_ex),
    .stallreq_mem_i(stallreq_mem),
    .div_req_i     (div_req),
    .div_ready_i   (div_ready),
    .excp_valid_i  (excp_valid),
    .excp_target_i (excp_target),
    .stall_o       (stall),
    .flush_o       (flush),
    .new_pc_o      (new_pc),
    .div_start_o   (div_start),
    .div_annul_o   (div_annul),
    .div_timeout_o (div_timeout)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: what the pipe is doing, described as flags plus the
  // cycle number at which the current divide wait began.
  bit              mFlushing, mWaiting, mDone;
  int              cyc = 0;
  int              waitStart = 0;
  logic            expFlush, expStart, expAnnul, expTimeout;
  logic [PC_W-1:0] expNewPc;

  // Outputs captured by the most recent applyStimulus call.
  logic [5:0]      sampStall;
  logic            sampFlush, sampStart, sampAnnul, sampTimeout;
  logic [PC_W-1:0] sampNewPc;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] modelStall();
    bit idle;
    idle = !mFlushing && !mWaiting && !mDone;
    if (mFlushing || excp_valid)                      return 6'b000000;
    if (stallreq_mem)                                 return 6'b011111;
    if (stallreq_ex || mWaiting || (idle && div_req)) return 6'b001111;
    if (stallreq_id)                                  return 6'b000111;
    return 6'b000000;
  endfunction

  // Drives one cycle of inputs, checks the combinational stall mid-cycle,
  // then checks every registered output just after the clock edge.
  task automatic applyStimulus(input logic r, input logic id, input logic ex, input logic mem,
                               input logic req, input logic ready, input logic excp,
                               input logic [PC_W-1:0] target);
    bit nF, nW, nD, nFl, nSt, nAn, nTo;
    logic [PC_W-1:0] nPc;
    int age;
    rst = r; stallreq_id = id; stallreq_ex = ex; stallreq_mem = mem;
    div_req = req; div_ready = ready; excp_valid = excp; excp_target = target;
    @(negedge clk);
    sampStall = stall;
    if (!r) checkOutput("stall", {26'd0, stall}, {26'd0, modelStall()});

    nF = 0; nW = mWaiting; nD = 0; nFl = 0; nSt = 0; nAn = 0;
    nTo = expTimeout; nPc = expNewPc;
    age = cyc - waitStart;
    if (r) begin
      nW = 0; nTo = 0; nPc = '0;
    end else if (excp && !mFlushing) begin
      nF = 1; nFl = 1; nPc = target; nAn = mWaiting; nW = 0;
    end else if (mWaiting) begin
      if (ready) begin
        nW = 0; nD = 1;
      end else if (age == DT - 1) begin
        nW = 0; nAn = 1; nTo = 1;
      end
    end else if (!mFlushing && !mDone && req && !mem) begin
      nW = 1; nSt = 1; waitStart = cyc + 1;
    end

    @(posedge clk);
    #1;
    cyc++;
    mFlushing = nF; mWaiting = nW; mDone = nD;
    expFlush = nFl; expStart = nSt; expAnnul = nAn; expTimeout = nTo; expNewPc = nPc;
    sampFlush = flush; sampStart = div_start; sampAnnul = div_annul;
    sampTimeout = div_timeout; sampNewPc = new_pc;
    checkOutput("flush", {31'd0, flush}, {31'd0, expFlush});
    checkOutput("new_pc", new_pc, expNewPc);
    checkOutput("div_start", {31'd0, div_start}, {31'd0, expStart});
    checkOutput("div_annul", {31'd0, div_annul}, {31'd0, expAnnul});
    checkOutput("div_timeout", {31'd0, div_timeout}, {31'd0, expTimeout});
  endtask

  task automatic idleCycle(input logic req);
    applyStimulus(0, 0, 0, 0, req, 0, 0, '0);
  endtask

  task automatic doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, '0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, '0);
  endtask

  initial begin
    doReset();
    checkOutput("reset_flush", {31'd0, sampFlush}, 32'd0);
    checkOutput("reset_newpc", sampNewPc, 32'd0);
    idleCycle(0);
    checkOutput("reset_stall", {26'd0, sampStall}, 32'd0);

    // Stall priority
    applyStimulus(0, 1, 0, 0, 0, 0, 0, '0);
    checkOutput("prio_id", {26'd0, sampStall}, 32'b000111);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, '0);
    checkOutput("prio_ex", {26'd0, sampStall}, 32'b001111);
    applyStimulus(0, 1, 1, 1, 0, 0, 0, '0);
    checkOutput("prio_mem", {26'd0, sampStall}, 32'b011111);
    idleCycle(0);
    checkOutput("prio_none", {26'd0, sampStall}, 32'd0);

    // Normal divide: ready on the fifth cycle after the request
    idleCycle(1);
    checkOutput("div_req_stall", {26'd0, sampStall}, 32'b001111);
    checkOutput("div_start_t1", {31'd0, sampStart}, 32'd1);
    for (int i = 0; i < 4; i++) idleCycle(1);
    applyStimulus(0, 0, 0, 0, 1, 1, 0, '0);
    idleCycle(1);
    checkOutput("div_done_stall", {26'd0, sampStall}, 32'd0);
    checkOutput("div_no_restart", {31'd0, sampStart}, 32'd0);
    idleCycle(0);
    idleCycle(0);

    // Exception in the third DIV_WAIT cycle
    idleCycle(1);
    idleCycle(1);
    idleCycle(1);
    applyStimulus(0, 0, 0, 0, 1, 0, 1, 32'hBFC00380);
    checkOutput("excp_stall", {26'd0, sampStall}, 32'd0);
    checkOutput("excp_flush", {31'd0, sampFlush}, 32'd1);
    checkOutput("excp_newpc", sampNewPc, 32'hBFC00380);
    checkOutput("excp_annul", {31'd0, sampAnnul}, 32'd1);
    idleCycle(0);
    checkOutput("excp_flush_end", {31'd0, sampFlush}, 32'd0);
    checkOutput("excp_newpc_hold", sampNewPc, 32'hBFC00380);
    idleCycle(0);

    // Ready and exception together: the exception wins
    idleCycle(1);
    idleCycle(1);
    applyStimulus(0, 0, 0, 0, 1, 1, 1, 32'h80000180);
    checkOutput("sim_flush", {31'd0, sampFlush}, 32'd1);
    checkOutput("sim_annul", {31'd0, sampAnnul}, 32'd1);
    idleCycle(0);
    idleCycle(0);

    // Ready in the timeout cycle: DIV_DONE, no timeout flag
    idleCycle(1);
    for (int i = 0; i < DT - 1; i++) idleCycle(1);
    applyStimulus(0, 0, 0, 0, 1, 1, 0, '0);
    checkOutput("edge_annul", {31'd0, sampAnnul}, 32'd0);
    checkOutput("edge_timeout", {31'd0, sampTimeout}, 32'd0);
    idleCycle(1);
    checkOutput("edge_done_stall", {26'd0, sampStall}, 32'd0);
    idleCycle(0);

    // Timeout with div_req held: abort, sticky flag, retry
    idleCycle(1);
    for (int i = 0; i < DT; i++) idleCycle(1);
    checkOutput("to_annul", {31'd0, sampAnnul}, 32'd1);
    checkOutput("to_flag", {31'd0, sampTimeout}, 32'd1);
    idleCycle(1);
    checkOutput("to_retry_start", {31'd0, sampStart}, 32'd1);
    checkOutput("to_sticky", {31'd0, sampTimeout}, 32'd1);

    // Reset in the middle of the retried divide
    idleCycle(1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, '0);
    checkOutput("rst_annul", {31'd0, sampAnnul}, 32'd0);
    checkOutput("rst_timeout", {31'd0, sampTimeout}, 32'd0);
    idleCycle(0);
    checkOutput("rst_stall", {26'd0, sampStall}, 32'd0);
    checkOutput("rst_no_annul", {31'd0, sampAnnul}, 32'd0);
    idleCycle(1);
    checkOutput("rst_fresh_start", {31'd0, sampStart}, 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 39) == 0, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
